hankasan_ctrl: RTL
==================

Name: hankasan_ctrl

Overview:
Sequencer that drives the 4 x 4-bit register bank / select-mux stage downstream.
Fetches 8-bit instructions from an external combinational ROM addressed by an internal PC, decodes them, and issues one-cycle load strobes plus a mux select and an immediate to the datapath.
Latches the datapath adder carry, supports conditional and unconditional jumps, and has a HALT state.

Parameters:
RESET_PC, 4'h0, PC value loaded on reset and on restart from HALT.
PC_W, 4, PC width. Jump targets are imm zero-extended to PC_W; the value must be >= 4.

Ports:
ck  input  1  clock; rising-edge active
res  input  1  asynchronous active-low reset
run  input  1  start/restart request, sampled in IDLE and HALT
instr  input  8  ROM data for address pc; must be valid during FETCH
carry  input  1  adder carry-out from the datapath; valid during EXEC of ADDI
pc  output  PC_W  ROM address (registered)
sel  output  2  register-bank mux select
imm  output  4  immediate added by the datapath
load  output  4  one-hot write strobe for registers q0..q3
busy  output  1  high in FETCH and EXEC
halted  output  1  high in HALT

Behaviour:
- Reset (res=0, async) forces:
  - state=IDLE.
  - pc=RESET_PC, IR=0, cflag=0.
  - sel, imm, load, busy and halted all 0.
  - Applies mid-instruction: any pending strobe is dropped immediately.
- States and transitions:
  - IDLE -> FETCH when run=1.
  - FETCH -> EXEC always. At the end of FETCH, IR <= instr.
  - EXEC -> FETCH, or -> HALT if the instruction is HALT.
  - HALT -> FETCH when run=1. On that transition pc<=RESET_PC and cflag<=0.
- Timing: 2 cycles per instruction. Load strobes are high only during EXEC, for exactly 1 cycle.
- Output source: sel, imm and load are functions of the registered IR and state only. There is no combinational path from instr to any output. Outside EXEC, sel, imm and load are 0.
- Decode: op=IR[7:6], f=IR[5:4], k=IR[3:0].
  - 00 MOV: load[f]=1, sel=k[1:0], imm=0.
  - 01 ADDI: load[f]=1, sel=f, imm=k. At the end of EXEC, cflag<=carry.
  - 10 JNC: no load. Next pc = k if cflag==0, else pc+1.
  - 11, f=00 JMP: no load. Next pc = k.
  - 11, f=11 HALT: no load. pc unchanged. Next state HALT.
  - 11, f=01/10: NOP. Next pc = pc+1.
- cflag rule: every executed instruction other than ADDI clears cflag at the end of EXEC. JNC evaluates cflag before it is cleared.
- PC update: happens only at the end of EXEC. pc+1 wraps modulo 2^PC_W (e.g. 4'hF -> 4'h0).
- run during FETCH or EXEC is ignored.
- MOV with f == k[1:0] is legal: it reloads the register with its own value.

Optional Feature:
SINGLE_STEP_EN.
- Defined: adds input port "step" (1 bit) and a state PAUSE.
  - EXEC goes to PAUSE instead of FETCH; busy=0 and all strobes are 0 in PAUSE.
  - PAUSE -> FETCH when step=1.
  - HALT still takes priority over PAUSE.
  - Reset in PAUSE goes to IDLE.
- Undefined: no step port, no PAUSE state; EXEC goes straight to FETCH.

Test Plan:
- Reset, then hold run=0 for 5 cycles -> pc=0, load=0, busy=0, halted=0. Assert res low mid-EXEC -> load drops to 0 immediately and state returns to IDLE.
- ROM[0]=8'h43 (ADDI q0,+3), run pulse -> cycle 2 has load=4'b0001, sel=0, imm=3. With carry=0, then ROM[1]=8'h85 (JNC 5) -> next fetch at pc=5.
- ADDI with carry=1, followed by JNC 9 -> pc increments to next (no jump). Next instruction is MOV, followed by JNC 9 -> jump taken (cflag was cleared by the MOV).
- ROM[0]=8'h2E (MOV q2,src q2) -> load=4'b0100, sel=2, imm=0 for exactly 1 cycle.
- ROM[15]=NOP (8'hD0) at pc=15 -> wraps to pc=0. ROM[n]=8'hF0 (HALT) -> halted=1 and pc holds. run pulse -> restart at RESET_PC with cflag=0.
- SINGLE_STEP_EN defined: after each EXEC, busy=0 until a step pulse; 3 step pulses execute exactly 3 instructions.

Source files
------------

// File: rtl/hankasan_ctrl.sv
// Two-cycle fetch/execute sequencer for the 4 x 4-bit register bank datapath.
// Optional single-step mode (PAUSE state plus a step input) is enabled by the SINGLE_STEP_EN macro.
module hankasan_ctrl #(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            ck,
    input  logic            res,
    input  logic            run,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [7:0]      instr,
    input  logic            carry,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      sel,
    output logic [3:0]      imm,
    output logic [3:0]      load,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
`ifdef SINGLE_STEP_EN
        S_PAUSE = 3'd4,
`endif
        S_HALT  = 3'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q;
    logic [7:0]      ir_q;
    logic            cflag_q;
    logic [PC_W-1:0] pc_q;
    logic [1:0]      sel_q;
    logic [3:0]      imm_q;
    logic [3:0]      load_q;
    logic            busy_q;
    logic            halted_q;

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] target_s;
    logic            cflag_d;
    logic            halt_d;

    // Strobe decode, applied to the word being latched into IR so it lines up with EXEC.
    function automatic logic [3:0] dec_load(input logic [7:0] ir);
        logic [3:0] ld;
        case (ir[7:6])
            2'b00, 2'b01: ld = 4'b0001 << ir[5:4];
            default:      ld = 4'b0000;
        endcase
        return ld;
    endfunction

    function automatic logic [1:0] dec_sel(input logic [7:0] ir);
        logic [1:0] s;
        case (ir[7:6])
            2'b00:   s = ir[1:0];
            2'b01:   s = ir[5:4];
            default: s = 2'b00;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] dec_imm(input logic [7:0] ir);
        logic [3:0] v;
        case (ir[7:6])
            2'b01:   v = ir[3:0];
            default: v = 4'h0;
        endcase
        return v;
    endfunction

    // Execute-stage results: next PC, next carry flag and halt request.
    always_comb begin
        pc_inc_s        = pc_q + PC_ONE;
        target_s        = {PC_W{1'b0}};
        target_s[3:0]   = ir_q[3:0];
        pc_d            = pc_inc_s;
        cflag_d         = 1'b0;
        halt_d          = 1'b0;
        case (ir_q[7:6])
            2'b00: pc_d = pc_inc_s;
            2'b01: begin
                pc_d    = pc_inc_s;
                cflag_d = carry;
            end
            2'b10: begin
                if (cflag_q) begin
                    pc_d = pc_inc_s;
                end else begin
                    pc_d = target_s;
                end
            end
            2'b11: begin
                case (ir_q[5:4])
                    2'b00: pc_d = target_s;
                    2'b11: begin
                        pc_d   = pc_q;
                        halt_d = 1'b1;
                    end
                    default: pc_d = pc_inc_s;
                endcase
            end
            default: pc_d = pc_inc_s;
        endcase
    end

    // Sequencer FSM with registered datapath controls; strobes default low every cycle.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_q  <= S_IDLE;
            ir_q     <= 8'h00;
            cflag_q  <= 1'b0;
            pc_q     <= RESET_PC;
            sel_q    <= 2'b00;
            imm_q    <= 4'h0;
            load_q   <= 4'h0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            sel_q  <= 2'b00;
            imm_q  <= 4'h0;
            load_q <= 4'h0;
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir_q    <= instr;
                    sel_q   <= dec_sel(instr);
                    imm_q   <= dec_imm(instr);
                    load_q  <= dec_load(instr);
                    state_q <= S_EXEC;
                    busy_q  <= 1'b1;
                end
                S_EXEC: begin
                    pc_q    <= pc_d;
                    cflag_q <= cflag_d;
                    if (halt_d) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
`ifdef SINGLE_STEP_EN
                        state_q <= S_PAUSE;
                        busy_q  <= 1'b0;
`else
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
`endif
                    end
                end
`ifdef SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
`endif
                S_HALT: begin
                    if (run) begin
                        state_q  <= S_FETCH;
                        pc_q     <= RESET_PC;
                        cflag_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc     = pc_q;
    assign sel    = sel_q;
    assign imm    = imm_q;
    assign load   = load_q;
    assign busy   = busy_q;
    assign halted = halted_q;

endmodule
